// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Two-port load/store controller in front of a word-only data
//               memory (combinational read, synchronous write). Round-robin
//               arbitration between port 0 (core LSU) and port 1 (debug/DMA),
//               byte/half/word loads with sign/zero extension, and byte/half
//               stores performed as read-modify-write. One registered response
//               per accepted request; at most one request in flight.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               pN_valid/ready      - request handshake, port N (0/1)
//               pN_addr/wdata/we    - byte address, store data, 1=store
//               pN_size/unsigned    - 00 byte, 01 half, 10 word; load extension
//               rsp_valid/id/rdata/err - one-cycle registered response
//               mem_a/wd/we/rd      - word-aligned memory interface
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_unsigned,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic              p1_unsigned,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_MERGE  = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    // One bit wider than the address so the limit itself is representable.
    localparam logic [ADDR_W:0] c_LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              r_last_grant;
    logic              r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_rdq;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic              w_misalign;
    logic              w_err;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    // ------------------------------------------------------------------
    // Arbitration: a sole requester wins; on contention the port that did
    // not win last time is granted.
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == c_IDLE);
    assign w_gnt0   = p0_valid & (~p1_valid | r_last_grant);
    assign w_gnt1   = p1_valid & ~w_gnt0;
    assign w_accept = w_idle & (p0_valid | p1_valid);

    // Ready is combinational; gating with rst_n keeps it low while reset is held.
    assign p0_ready = rst_n & w_idle & w_gnt0;
    assign p1_ready = rst_n & w_idle & w_gnt1;

    assign mem_a = {r_addr[ADDR_W-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Error decode on the latched request.
    // ------------------------------------------------------------------
    always_comb begin
        w_misalign = 1'b0;
        case (r_size)
            c_SZ_BYTE: w_misalign = 1'b0;
            c_SZ_HALF: w_misalign = r_addr[0];
            c_SZ_WORD: w_misalign = (r_addr[1:0] != 2'b00);
            default:   w_misalign = 1'b1;  // size 11 is illegal
        endcase
    end

    assign w_err = w_misalign | ({1'b0, r_addr} >= c_LIMIT);

    // ------------------------------------------------------------------
    // Load lane extraction and extension, taken from the word being read
    // in ACCESS so the response can be registered on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

        w_load = mem_rd;
        case (r_size)
            c_SZ_BYTE: w_load = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = r_uns ? {16'h0000, w_half}   : {{16{w_half[15]}}, w_half};
            default:   w_load = mem_rd;
        endcase
    end

    // ------------------------------------------------------------------
    // Sub-word store merge into the word captured during ACCESS
    // (little-endian lanes).
    // ------------------------------------------------------------------
    always_comb begin
        w_merged = r_rdq;
        if (r_size == c_SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_wdata[15:0];
            end else begin
                w_merged[15:0]  = r_wdata[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and memory-side outputs. mem_we is only raised in
    // ACCESS (error-free word store) or MERGE; because it is decoded from
    // the state, an asynchronous reset drops it immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_we       = 1'b0;
        mem_wd       = 32'h0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (w_err || !r_we) begin
                    w_next_state = c_RESP;
                end else if (r_size == c_SZ_WORD) begin
                    mem_we       = 1'b1;
                    mem_wd       = r_wdata;
                    w_next_state = c_RESP;
                end else begin
                    w_next_state = c_MERGE;
                end
            end
            c_MERGE: begin
                mem_we       = 1'b1;
                mem_wd       = w_merged;
                w_next_state = c_RESP;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, read capture and registered response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;  // port 0 wins the first contention
            r_id         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_rdq        <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= (w_next_state == c_RESP);

            if (w_accept) begin
                r_last_grant <= w_gnt1;
                r_id         <= w_gnt1;
                r_addr       <= w_gnt1 ? p1_addr     : p0_addr;
                r_wdata      <= w_gnt1 ? p1_wdata    : p0_wdata;
                r_we         <= w_gnt1 ? p1_we       : p0_we;
                r_size       <= w_gnt1 ? p1_size     : p0_size;
                r_uns        <= w_gnt1 ? p1_unsigned : p0_unsigned;
            end

            if (r_state == c_ACCESS) begin
                r_rdq <= mem_rd;
                if (w_next_state == c_RESP) begin
                    rsp_id    <= r_id;
                    rsp_err   <= w_err;
                    rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load;
                end
            end

            if (r_state == c_MERGE) begin
                rsp_id    <= r_id;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Holds a behavioural
//               64x32 memory, a reference memory and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 64;

    logic              clk;
    logic              rst_n;
    logic              p0_valid, p1_valid;
    logic              p0_ready, p1_ready;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_we, p1_we;
    logic [1:0]        p0_size, p1_size;
    logic              p0_unsigned, p1_unsigned;
    logic              rsp_valid, rsp_id, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd, mem_rd;
    logic              mem_we;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, synchronous write.
    logic [31:0] ram     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          acc;
        bit          wr;
        int          widx;
        logic [31:0] wval;
    } exp_t;

    exp_t sbq[$];
    bit   glog[$];
    int   gcyc[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0, n_fail = 0;
    bit   we_seen;
    logic [31:0] last_rdata;
    logic        last_err, last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request against ref_mem.
    function automatic exp_t model(input bit id, input logic [31:0] addr, input logic [31:0] wdata,
                                   input bit we, input logic [1:0] size, input bit uns);
        exp_t        e;
        logic [31:0] word, m, v;
        int          sh;
        e.id    = id;
        e.err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(MEM_WORDS * 4));
        e.rdata = 32'h0;
        e.wr    = 1'b0;
        e.widx  = int'(addr[7:2]);
        e.wval  = 32'h0;
        e.acc   = 0;
        e.lat   = (e.err || !we || size == 2'b10) ? 2 : 3;
        word    = ref_mem[addr[7:2]];
        sh      = 8 * int'(addr[1:0]);
        if (!e.err) begin
            if (!we) begin
                if (size == 2'b10) e.rdata = word;
                else if (size == 2'b00) begin
                    v = (word >> sh) & 32'hFF;
                    e.rdata = (!uns && v[7]) ? (v | 32'hFFFFFF00) : v;
                end else begin
                    v = (word >> sh) & 32'hFFFF;
                    e.rdata = (!uns && v[15]) ? (v | 32'hFFFF0000) : v;
                end
            end else begin
                e.wr = 1'b1;
                if (size == 2'b10) e.wval = wdata;
                else begin
                    m = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
                    e.wval = (word & ~m) | ((wdata << sh) & m);
                end
            end
        end
        return e;
    endfunction

    // Acceptance monitor: expected response is queued when a request is taken.
    always @(posedge clk) begin : mon_accept
        exp_t e;
        if (rst_n) begin
            if (p0_valid && p0_ready) begin
                e = model(1'b0, p0_addr, p0_wdata, p0_we, p0_size, p0_unsigned);
                e.acc = cyc;
                sbq.push_back(e);
                glog.push_back(1'b0);
                gcyc.push_back(cyc);
            end
            if (p1_valid && p1_ready) begin
                e = model(1'b1, p1_addr, p1_wdata, p1_we, p1_size, p1_unsigned);
                e.acc = cyc;
                sbq.push_back(e);
                glog.push_back(1'b1);
                gcyc.push_back(cyc);
            end
        end
        if (mem_we) we_seen = 1'b1;
        cyc++;
    end

    // Response checker: pops one expectation per response strobe.
    always @(negedge clk) begin : mon_rsp
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                if (e.wr) ref_mem[e.widx] = e.wval;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                last_id    = rsp_id;
            end
        end
    end

    task automatic issue(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit we, input logic [1:0] size, input bit uns);
        bit got = 1'b0;
        @(negedge clk);
        if (port == 1'b0) begin
            p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_size = size; p0_unsigned = uns;
            p0_valid = 1'b1;
        end else begin
            p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_size = size; p1_unsigned = uns;
            p1_valid = 1'b1;
        end
        for (int k = 0; k < 60; k++) begin
            #1;
            if ((port == 1'b0 && p0_ready) || (port == 1'b1 && p1_ready)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 32'(port ? p1_ready : p0_ready), 32'h1);
        @(posedge clk);
        #1;
        if (port == 1'b0) p0_valid = 1'b0;
        else              p1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'h0);
    endtask

    task automatic rand_port(input bit port, input int n);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h100 + $urandom_range(0, 255);
            else if (r == 1) a = 32'h8000_0000 | $urandom_range(0, 255);
            else             a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(port, a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end
    endtask

    initial begin : stim
        int mism;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[0] = 32'hFACEFACE;  ref_mem[0] = 32'hFACEFACE;
        p0_valid = 1'b1; p1_valid = 1'b0;
        p0_addr = '0; p0_wdata = '0; p0_we = 1'b0; p0_size = 2'b00; p0_unsigned = 1'b0;
        p1_addr = '0; p1_wdata = '0; p1_we = 1'b0; p1_size = 2'b00; p1_unsigned = 1'b0;
        we_seen = 1'b0; last_rdata = '0; last_err = 1'b0; last_id = 1'b0;

        // Reset state, with a request already pending on port 0.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_ready", 32'(p0_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        p0_valid = 1'b0;
        rst_n = 1'b1;

        // T3: contention straight after reset alternates 0,1,0,1.
        glog.delete(); gcyc.delete();
        fork
            begin issue(1'b0, 32'h4, 32'h0, 1'b0, 2'b10, 1'b0); issue(1'b0, 32'h8, 32'h0, 1'b0, 2'b10, 1'b0); end
            begin issue(1'b1, 32'hC, 32'h0, 1'b0, 2'b10, 1'b0); issue(1'b1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0); end
        join
        drain();
        chk("t3_grants", 32'(glog.size()), 32'h4);
        if (glog.size() == 4) begin
            chk("t3_grant0", 32'(glog[0]), 32'h0);
            chk("t3_grant1", 32'(glog[1]), 32'h1);
            chk("t3_grant2", 32'(glog[2]), 32'h0);
            chk("t3_grant3", 32'(glog[3]), 32'h1);
            chk("t3_regrant_gap", 32'(gcyc[1] - gcyc[0]), 32'h3);
        end

        // T1: sub-word loads from FACEFACE.
        issue(1'b0, 32'h1, 32'h0, 1'b0, 2'b00, 1'b0);
        drain();
        chk("t1_lb", last_rdata, 32'hFFFFFFFA);
        chk("t1_lb_err", 32'(last_err), 32'h0);
        chk("t1_lb_id", 32'(last_id), 32'h0);
        issue(1'b0, 32'h2, 32'h0, 1'b0, 2'b01, 1'b1);
        drain();
        chk("t1_lhu", last_rdata, 32'h0000FACE);

        // T2: byte store via read-modify-write, then read back.
        issue(1'b0, 32'h1, 32'h5A, 1'b1, 2'b00, 1'b0);
        drain();
        chk("t2_ram0", ram[0], 32'hFACE5ACE);
        issue(1'b0, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
        drain();
        chk("t2_lw", last_rdata, 32'hFACE5ACE);

        // T4: misaligned and out-of-range requests.
        we_seen = 1'b0;
        issue(1'b1, 32'h3, 32'h0, 1'b0, 2'b01, 1'b0);
        drain();
        chk("t4_lh_err", 32'(last_err), 32'h1);
        chk("t4_lh_rdata", last_rdata, 32'h0);
        chk("t4_lh_id", 32'(last_id), 32'h1);
        issue(1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0);
        drain();
        chk("t4_sw_err", 32'(last_err), 32'h1);
        chk("t4_no_we", 32'(we_seen), 32'h0);
        chk("t4_ram0", ram[0], 32'hFACE5ACE);

        // T5: reset during MERGE of a half store.
        @(negedge clk);
        ram[0] = 32'hFACEFACE;  ref_mem[0] = 32'hFACEFACE;
        issue(1'b0, 32'h2, 32'h1234, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (mem_we) break;
            @(negedge clk);
        end
        chk("t5_merge_we", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_we_drop", 32'(mem_we), 32'h0);
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        chk("t5_ram0", ram[0], 32'hFACEFACE);

        // T6: random concurrent traffic against the reference model.
        fork
            rand_port(1'b0, 30);
            rand_port(1'b1, 30);
        join
        drain();
        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("t6_ram_match", 32'(mism), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
